mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
Upstream operand sequencer for the 4x4 Vedic MAC datapath. It accepts a stream of packed operand pairs over a valid/ready byte interface and buffers up to DEPTH pairs. It then clears the MAC accumulator, streams the pairs into the MAC one per cycle, and returns the final 8-bit dot-product result on a valid/ready output. It also drives zero operands whenever it is not streaming, so the accumulator holds its value.

Parameters:
DEPTH, 8, maximum number of operand pairs per vector (power of 2, 2..16)
PTR_W, 3, log2(DEPTH); width of buffer pointers and count

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept a pair
in_data  input  8  packed pair: a=in_data[3:0], b=in_data[7:4]
in_last  input  1  current pair is the last of the vector
mac_a  output  4  operand a to MAC
mac_b  output  4  operand b to MAC
mac_clr  output  1  registered active-high clear to MAC accumulator reset
acc_in  input  8  MAC accumulator output C (registered in MAC)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  8  dot product modulo 256
res_count  output  PTR_W+1  number of pairs in the vector (1..DEPTH)
res_trunc  output  1  vector hit DEPTH without in_last
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all pointers and count=0.
  - Outputs after reset: mac_a=0, mac_b=0, mac_clr=0, res_valid=0, res_data=0, res_count=0, res_trunc=0, in_ready=1, busy=0.
  - Buffer contents are don't-care.
- States and transitions:
  - IDLE: in_ready=1. A handshake (in_valid&in_ready) writes buf[0] and sets wr_ptr=1.
    - If in_last=1, go to CLEAR; else go to LOAD.
  - LOAD: in_ready=1. Each handshake writes buf[wr_ptr] and increments wr_ptr.
    - Go to CLEAR on a handshake with in_last=1, or when the handshake fills entry DEPTH-1.
    - If the buffer fills with in_last=0, set trunc=1 and ignore in_last afterwards.
    - Idle cycles (in_valid=0) in LOAD are allowed and add no pairs.
  - CLEAR: one cycle. Registered mac_clr=1, mac_a=mac_b=0, count=wr_ptr, rd_ptr=0. Go to RUN.
  - RUN: exactly count cycles. mac_a/mac_b=buf[rd_ptr] (registered outputs, one pair per cycle); rd_ptr increments each cycle. Leave RUN after the cycle that presents pair count-1, then go to CAPTURE.
  - CAPTURE: one cycle. mac_a=mac_b=0. At the end of this cycle, res_data<=acc_in, res_count<=count, res_trunc<=trunc, res_valid<=1. Go to DONE.
  - DONE: hold res_* stable while res_valid=1 and res_ready=0.
    - On res_valid&res_ready: clear res_valid, wr_ptr, and trunc, then go to IDLE.
- in_ready=0 in CLEAR, RUN, CAPTURE and DONE.
- Operand gating:
  - mac_a/mac_b are 0 in every state except RUN, so the MAC adds 0 and the accumulator holds.
  - mac_clr is 1 only in CLEAR.
- Arithmetic: the result is the MAC's 8-bit wrapping sum; there is no overflow detection.
- Latency: from the clock edge accepting the last pair to res_valid=1 is count+3 edges (CLEAR 1, RUN count, CAPTURE 1, then the registered res_valid).
- Simultaneous events:
  - In DONE, a handshake and a new in_valid in the same cycle: the new pair is not accepted (in_ready=0); it is accepted in IDLE on the following cycle.
  - in_last on the entry that fills the buffer: trunc=0.
- Reset mid-operation (LOAD/RUN/DONE): return to IDLE immediately.
  - The pending result is lost and the buffer is abandoned.
  - mac_a/mac_b go to 0 asynchronously.

Test Plan:
- Reset then vector (a=3,b=5),(a=2,b=7) with in_last on 2nd, MAC model attached -> res_data=29, res_count=2, res_trunc=0; res_valid rises 5 edges after the last accept.
- Wrap: (15,15),(15,15) -> res_data=194 (450 mod 256); a second vector (1,1) alone -> res_data=1, proving CLEAR cleared the accumulator.
- Eight pairs (1,2) with in_last never asserted, DEPTH=8 -> accept stops after 8, in_ready=0, res_count=8, res_data=16, res_trunc=1.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid/res_data stable, in_ready=0, mac_a=mac_b=0, acc_in unchanged; release res_ready -> IDLE with in_ready=1 next cycle.
- Input gaps: in_valid toggling 1,0,0,1(last) with pairs (4,4),(2,3) -> res_count=2, res_data=22.
- Assert rst during RUN of a 6-pair vector -> busy=0, mac_a=mac_b=0, res_valid=0 immediately; next vector (5,5) -> res_data=25.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for the 4x4 MAC datapath.
// Collects up to DEPTH packed operand pairs, clears the MAC accumulator,
// streams the pairs one per cycle, then returns the accumulator value.
// Operands are forced to zero outside RUN so the accumulator holds its value.
module mac_dot_sequencer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [3:0]       mac_a,
  output logic [3:0]       mac_b,
  output logic             mac_clr,
  input  logic [7:0]       acc_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [PTR_W:0]   res_count,
  output logic             res_trunc,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [7:0]       buf_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             trunc_reg;
  logic [3:0]       mac_a_reg, mac_b_reg;
  logic             mac_clr_reg;
  logic             res_valid_reg;
  logic [7:0]       res_data_reg;
  logic [PTR_W:0]   res_count_reg;
  logic             res_trunc_reg;

  logic             in_fire;
  logic             res_fire;
  logic             fill_hit;
  logic [7:0]       rd_pair;

  assign in_ready  = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  assign busy      = (state_reg != S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign res_fire  = res_valid_reg && res_ready;
  // The pair being written now occupies the last buffer slot.
  assign fill_hit  = (wr_ptr_reg == LAST_IDX);
  assign rd_pair   = buf_mem[rd_ptr_reg[PTR_W-1:0]];

  assign mac_a     = mac_a_reg;
  assign mac_b     = mac_b_reg;
  assign mac_clr   = mac_clr_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_count = res_count_reg;
  assign res_trunc = res_trunc_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_fire) begin
          state_next = in_last ? S_CLEAR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_fire && (in_last || fill_hit)) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR:   state_next = S_RUN;
      S_RUN: begin
        // rd_ptr counts pairs already presented; stop once all are out.
        if (rd_ptr_reg == count_reg) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: state_next = S_DONE;
      S_DONE: begin
        if (res_fire) begin
          state_next = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Operand buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_mem[wr_ptr_reg[PTR_W-1:0]] <= in_data;
    end
  end

  // Write pointer and truncation flag for the vector being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      trunc_reg  <= 1'b0;
    end else begin
      if (in_fire) begin
        wr_ptr_reg <= (state_reg == S_IDLE) ? (PTR_W+1)'(1) : wr_ptr_reg + 1'b1;
        if ((state_reg == S_LOAD) && fill_hit && !in_last) begin
          trunc_reg <= 1'b1;
        end
      end else if ((state_reg == S_DONE) && res_fire) begin
        wr_ptr_reg <= '0;
        trunc_reg  <= 1'b0;
      end
    end
  end

  // Read pointer and latched pair count for streaming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (state_reg == S_CLEAR) begin
        count_reg <= wr_ptr_reg;
      end
      if (state_next == S_CLEAR) begin
        rd_ptr_reg <= '0;
      end else if (state_next == S_RUN) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Registered MAC drive: outputs line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_a_reg   <= '0;
      mac_b_reg   <= '0;
      mac_clr_reg <= 1'b0;
    end else begin
      mac_clr_reg <= (state_next == S_CLEAR);
      if (state_next == S_RUN) begin
        mac_a_reg <= rd_pair[3:0];
        mac_b_reg <= rd_pair[7:4];
      end else begin
        mac_a_reg <= '0;
        mac_b_reg <= '0;
      end
    end
  end

  // Result capture and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_count_reg <= '0;
      res_trunc_reg <= 1'b0;
    end else begin
      if (state_reg == S_CAPTURE) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= acc_in;
        res_count_reg <= count_reg;
        res_trunc_reg <= trunc_reg;
      end else if (res_fire) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural 4x4 MAC attached.
module tb_mac_dot_sequencer;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [3:0]       mac_a, mac_b;
  logic             mac_clr;
  logic [7:0]       acc;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [PTR_W:0]   res_count;
  logic             res_trunc;
  logic             busy;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc        = 0;
  int accept_cyc = 0;

  mac_dot_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .acc_in    (acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .res_trunc (res_trunc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: registered accumulator with synchronous clear, 8-bit wrap.
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= 8'd0;
    else if (mac_clr) acc <= 8'd0;
    else acc <= acc + ({4'd0, mac_a} * {4'd0, mac_b});
  end

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one pair and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {b, a};
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send timeout", 0, 1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("send a=%0d b=%0d last=%0d", a, b, last);
  endtask

  // Wait for the result, check it, then complete the output handshake.
  task automatic get_result(input string tag, input int exp_data, input int exp_count,
                            input int exp_trunc, input int exp_lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, " res_valid timeout"}, 0, 1);
    // Edges counted inclusively, the accepting edge being edge 1.
    check({tag, " latency"}, cyc - accept_cyc + 1, exp_lat);
    check({tag, " res_data"}, res_data, exp_data);
    check({tag, " res_count"}, res_count, exp_count);
    check({tag, " res_trunc"}, res_trunc, exp_trunc);
    $display("result %s data=%0d count=%0d trunc=%0d", tag, res_data, res_count, res_trunc);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, " in_ready after ack"}, in_ready, 1);
    check({tag, " res_valid after ack"}, res_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst mac_a", mac_a, 0);
    check("rst mac_b", mac_b, 0);
    check("rst mac_clr", mac_clr, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst res_count", res_count, 0);
    check("rst res_trunc", res_trunc, 0);
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);

    // Basic vector: 3*5 + 2*7 = 29.
    send(4'd3, 4'd5, 1'b0);
    send(4'd2, 4'd7, 1'b1);
    check("basic in_ready in CLEAR", in_ready, 0);
    check("basic mac_clr in CLEAR", mac_clr, 1);
    check("basic busy", busy, 1);
    get_result("basic", 29, 2, 0, 5);

    // Wrap: 225 + 225 = 450 -> 194; then a lone (1,1) gives 1.
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    get_result("wrap", 194, 2, 0, 5);
    send(4'd1, 4'd1, 1'b1);
    get_result("single", 1, 1, 0, 4);

    // Truncation: eight (1,2) pairs without in_last -> 16, count 8.
    for (int i = 0; i < 8; i++) send(4'd1, 4'd2, 1'b0);
    check("trunc in_ready after fill", in_ready, 0);
    get_result("trunc", 16, 8, 1, 11);

    // Backpressure: (3,3) -> 9, held for 10 cycles.
    send(4'd3, 4'd3, 1'b1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("bp res_valid timeout", 0, 1);
    end
    for (int i = 0; i < 10; i++) begin
      check("bp res_valid", res_valid, 1);
      check("bp res_data", res_data, 9);
      check("bp in_ready", in_ready, 0);
      check("bp mac_a", mac_a, 0);
      check("bp mac_b", mac_b, 0);
      check("bp acc", acc, 9);
      @(negedge clk);
    end
    // Release while a new pair is offered: not taken in DONE, taken in IDLE.
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {4'd6, 4'd2};
    in_last   = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("bp in_ready after ack", in_ready, 1);
    check("bp busy after ack", busy, 0);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp next accepted busy", busy, 1);
    get_result("after_bp", 12, 1, 0, 4);

    // Input gaps: (4,4), two idle cycles, (2,3) last -> 22.
    send(4'd4, 4'd4, 1'b0);
    repeat (2) @(posedge clk);
    send(4'd2, 4'd3, 1'b1);
    get_result("gaps", 22, 2, 0, 5);

    // Reset during RUN of a 6-pair vector.
    for (int i = 0; i < 5; i++) send(4'd7, 4'd9, 1'b0);
    send(4'd7, 4'd9, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst busy before", busy, 1);
    check("midrst mac_a before", mac_a, 7);
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst mac_a", mac_a, 0);
    check("midrst mac_b", mac_b, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(4'd5, 4'd5, 1'b1);
    get_result("post_rst", 25, 1, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
